mult_hilo_ctrl: RTL and testbench

MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

---
 rtl/mult_hilo_ctrl.sv | 118 +++++++++++
 tb/tb_mult_hilo_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: iterative shift-add unsigned multiplier with HI/LO
// architectural registers and pipeline stall/hazard control.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no multiply in flight; mult_we launches a new one
// RUN   | one shift-add iteration per clock, WIDTH iterations in total
//
// WIDTH must equal 2**CNT_W so that the iteration counter reaches
// WIDTH-1 exactly on the final iteration.
module mult_hilo_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_we,
    input  logic             mf_req,
    input  logic             mf_hilo_sel,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic               start;
    logic               last;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     sum;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: launch from IDLE, retire after the last iteration
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (mult_we) begin
                    start     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One shift-add step. The adder carry lands in the top bit of the
    // shifted product, so no separate carry register has to persist.
    always_comb begin
        sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_nxt = {sum, prod[WIDTH-1:1]};
    end

    // Datapath, iteration counter, HI/LO and the completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (start) begin
                mcand <= rs_val;
                prod  <= {{WIDTH{1'b0}}, rt_val};
                cnt   <= '0;
            end else if (state == RUN) begin
                prod <= prod_nxt;
                cnt  <= cnt + CNT_W'(1);
                if (last) begin
                    hi <= prod_nxt[2*WIDTH-1:WIDTH];
                    lo <= prod_nxt[WIDTH-1:0];
                end
            end
        end
    end

    // Status, hazard stall and the MFHI/MFLO read path
    always_comb begin
        busy     = (state == RUN);
        stall    = busy & (mf_req | mult_we);
        hilo_out = mf_hilo_sel ? lo : hi;
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb_mult_hilo_ctrl: vector table plus corner-case sequences for the
// HI/LO multiplier; expected products are queued at issue and retired
// against the DUT when done pulses.
module tb_mult_hilo_ctrl;

    logic        clk;
    logic        rst;
    logic        mult_we;
    logic        mf_req;
    logic        mf_hilo_sel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] hilo_out;
    logic        busy;
    logic        stall;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [63:0] sb_q[$];

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[6];

    mult_hilo_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .mult_we     (mult_we),
        .mf_req      (mf_req),
        .mf_hilo_sel (mf_hilo_sel),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .hilo_out    (hilo_out),
        .busy        (busy),
        .stall       (stall),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        mf_hilo_sel = 1'b0;
        #1 h = hilo_out;
        mf_hilo_sel = 1'b1;
        #1 l = hilo_out;
        mf_hilo_sel = 1'b0;
        #1;
    endtask

    // Retire one expected product from the scoreboard against HI/LO
    task automatic retire(input string tag);
        logic [63:0] e;
        logic [31:0] h;
        logic [31:0] l;
        if (sb_q.size() == 0) begin
            check({tag, "_unexpected_done"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            read_hilo(h, l);
            check({tag, "_hi"}, h, e[63:32]);
            check({tag, "_lo"}, l, e[31:0]);
        end
    endtask

    // Issue one multiply from IDLE and follow it to completion
    task automatic run_mult(input string tag, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] eh, input logic [31:0] el);
        int busy_cnt;
        int done_cnt;
        int done_at;
        @(negedge clk);
        rs_val  = rs;
        rt_val  = rt;
        mult_we = 1'b1;
        sb_q.push_back({eh, el});
        @(negedge clk);
        mult_we  = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
                retire(tag);
            end
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, busy_cnt, 32);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_at, 32);
    endtask

    initial begin
        logic [31:0] h;
        logic [31:0] l;
        logic [31:0] old_hi;
        int stall_cnt;
        int busy_cnt;
        int done_cnt;
        int bad;
        int consec;
        int first_done;
        logic prev_done;
        logic [63:0] m;

        vecs[0] = '{32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000};
        vecs[3] = '{32'd0,        32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        for (int k = 4; k < 6; k++) begin
            vecs[k].rs = $urandom;
            vecs[k].rt = $urandom;
            m = {32'd0, vecs[k].rs} * {32'd0, vecs[k].rt};
            vecs[k].hi = m[63:32];
            vecs[k].lo = m[31:0];
        end

        rst         = 1'b1;
        mult_we     = 1'b0;
        mf_req      = 1'b0;
        mf_hilo_sel = 1'b0;
        rs_val      = '0;
        rt_val      = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        mf_req  = 1'b1;
        mult_we = 1'b1;
        #1 check("rst_stall", stall, 0);
        mf_req  = 1'b0;
        mult_we = 1'b0;
        read_hilo(h, l);
        check("rst_hi", h, 0);
        check("rst_lo", l, 0);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            run_mult($sformatf("vec%0d", k), vecs[k].rs, vecs[k].rt, vecs[k].hi, vecs[k].lo);
        end

        // mf_req held across a multiply: stall for the whole run, old HI visible
        old_hi = vecs[5].hi;
        @(negedge clk);
        rs_val  = 32'h0001_0000;
        rt_val  = 32'h0001_0000;
        mult_we = 1'b1;
        sb_q.push_back({32'h0000_0001, 32'h0000_0000});
        @(negedge clk);
        mult_we   = 1'b0;
        mf_req    = 1'b1;
        stall_cnt = 0;
        done_cnt  = 0;
        bad       = 0;
        for (int i = 0; i < 40; i++) begin
            if (stall) stall_cnt++;
            if (busy && hilo_out !== old_hi) bad++;
            if (done) begin
                done_cnt++;
                retire("mfreq");
            end
            @(negedge clk);
        end
        mf_req = 1'b0;
        check("mfreq_stall_cycles", stall_cnt, 32);
        check("mfreq_partial_leak", bad, 0);
        check("mfreq_done_count", done_cnt, 1);

        // Back-to-back issue: second mult_we held high while busy
        @(negedge clk);
        rs_val  = 32'd3;
        rt_val  = 32'd5;
        mult_we = 1'b1;
        sb_q.push_back({32'h0, 32'h0000_000F});
        sb_q.push_back({32'h0, 32'h0000_002A});
        @(negedge clk);
        rs_val     = 32'd7;
        rt_val     = 32'd6;
        stall_cnt  = 0;
        busy_cnt   = 0;
        done_cnt   = 0;
        consec     = 0;
        first_done = -1;
        prev_done  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (first_done >= 0 && i == first_done + 1) mult_we = 1'b0;
            #1;
            if (stall) stall_cnt++;
            if (busy) busy_cnt++;
            if (done && prev_done) consec++;
            prev_done = done;
            if (done) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = i;
                    check("b2b_stall_at_first_done", stall, 0);
                end else begin
                    check("b2b_second_done_cycle", i, 65);
                end
                retire("b2b");
            end
            @(negedge clk);
        end
        mult_we = 1'b0;
        check("b2b_first_done_cycle", first_done, 32);
        check("b2b_stall_cycles", stall_cnt, 32);
        check("b2b_busy_cycles", busy_cnt, 64);
        check("b2b_done_count", done_cnt, 2);
        check("b2b_done_consecutive", consec, 0);

        // Reset during RUN cycle 10 aborts with no result and no done
        @(negedge clk);
        rs_val  = 32'd9;
        rt_val  = 32'd11;
        mult_we = 1'b1;
        @(negedge clk);
        mult_we = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        read_hilo(h, l);
        check("abort_hi", h, 0);
        check("abort_lo", l, 0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("abort_late_done", done_cnt, 0);

        // Reset wins over mult_we at the same edge
        rs_val  = 32'd4;
        rt_val  = 32'd4;
        rst     = 1'b1;
        mult_we = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        mult_we = 1'b0;
        check("rst_priority_busy", busy, 0);

        run_mult("post_reset", 32'd12, 32'd12, 32'd0, 32'd144);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
